// File: rtl/onchip_flash_pkg.sv
// Shared encodings for the on-chip flash controller: command opcodes, CSR map,
// FSM state enum and the control-register word builder.
package onchip_flash_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_ERASE = 2'b10,
    OP_RSVD  = 2'b11
  } cmd_op_e;

  localparam logic CSR_STATUS_ADDR = 1'b0;
  localparam logic CSR_CTRL_ADDR   = 1'b1;

  localparam int STAT_BUSY_LSB  = 0;
  localparam int STAT_WRITE_OK  = 3;
  localparam int STAT_ERASE_OK  = 4;

  localparam int CTRL_PAGE_LSB   = 0;
  localparam int CTRL_SECTOR_LSB = 20;
  localparam int CTRL_WP_LSB     = 23;

  localparam logic [2:0]  SECTOR_NONE = 3'b111;
  localparam logic [19:0] PAGE_NONE   = 20'hFFFFF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_UNPROT,
    S_ERASE,
    S_WR,
    S_RD,
    S_POLL,
    S_CHECK,
    S_REPROT,
    S_RESP
  } state_e;

  // Control word with page erase disabled; sector 3'b111 means no sector erase.
  function automatic logic [31:0] ctrl_word(input logic [4:0] wp, input logic [2:0] sector);
    logic [31:0] w;
    w = '0;
    w[CTRL_PAGE_LSB +: 20]  = PAGE_NONE;
    w[CTRL_SECTOR_LSB +: 3] = sector;
    w[CTRL_WP_LSB +: 5]     = wp;
    return w;
  endfunction

endpackage

// File: rtl/onchip_flash_ctrl_if.sv
// Command/response and Avalon-MM bus bundles for the on-chip flash controller.
// Handshake: a command transfers on a rising clock edge where cmd_valid and cmd_ready are both high;
// the requester holds cmd_valid and all cmd_* fields stable until that edge. resp_valid is a
// one-cycle pulse with no back-pressure.
interface flash_cmd_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [16:0] cmd_addr;
  logic [2:0]  cmd_sector;
  logic [31:0] cmd_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_sector, cmd_wdata,
    input  cmd_ready, resp_valid, resp_rdata, resp_error
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_sector, cmd_wdata,
    output cmd_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

interface flash_avmm_if;
  logic        avmm_csr_addr;
  logic        avmm_csr_read;
  logic        avmm_csr_write;
  logic [31:0] avmm_csr_writedata;
  logic [31:0] avmm_csr_readdata;
  logic [16:0] avmm_data_addr;
  logic        avmm_data_read;
  logic        avmm_data_write;
  logic [31:0] avmm_data_writedata;
  logic [1:0]  avmm_data_burstcount;
  logic [31:0] avmm_data_readdata;
  logic        avmm_data_waitrequest;
  logic        avmm_data_readdatavalid;

  modport master (
    output avmm_csr_addr, avmm_csr_read, avmm_csr_write, avmm_csr_writedata,
    output avmm_data_addr, avmm_data_read, avmm_data_write, avmm_data_writedata,
    output avmm_data_burstcount,
    input  avmm_csr_readdata, avmm_data_readdata, avmm_data_waitrequest, avmm_data_readdatavalid
  );
  modport slave (
    input  avmm_csr_addr, avmm_csr_read, avmm_csr_write, avmm_csr_writedata,
    input  avmm_data_addr, avmm_data_read, avmm_data_write, avmm_data_writedata,
    input  avmm_data_burstcount,
    output avmm_csr_readdata, avmm_data_readdata, avmm_data_waitrequest, avmm_data_readdatavalid
  );
endinterface

// File: rtl/onchip_flash_ctrl.sv
// Avalon-MM initiator for the on-chip flash: one command at a time, with write-protect
// lifted around each write/erase and status polling until the flash goes idle.
module onchip_flash_ctrl
  import onchip_flash_pkg::*;
#(
  parameter logic [23:0] POLL_LIMIT = 24'd1048575,
  parameter logic [4:0]  WP_MASK    = 5'b11111
) (
  input  logic        clock,
  input  logic        reset,
  flash_cmd_if.slave  cmd,
  flash_avmm_if.master avmm,
  output state_e      state_o
);

  state_e      state_q, state_d;
  cmd_op_e     op_q, op_d;
  logic [16:0] addr_q, addr_d;
  logic [2:0]  sector_q, sector_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  stat_ok_q, stat_ok_d;   // {erase ok, write ok} from the final status read
  logic        err_q, err_d;
  logic [23:0] poll_cnt_q, poll_cnt_d;
  logic        poll_ph_q, poll_ph_d;
  logic        rd_acc_q, rd_acc_d;

  logic unused_status;
  assign unused_status = ^{avmm.avmm_csr_readdata[31:5], avmm.avmm_csr_readdata[2]};

  assign state_o                   = state_q;
  assign avmm.avmm_data_burstcount = 2'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_READ;
      addr_q     <= '0;
      sector_q   <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      stat_ok_q  <= '0;
      err_q      <= 1'b0;
      poll_cnt_q <= '0;
      poll_ph_q  <= 1'b0;
      rd_acc_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      sector_q   <= sector_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      stat_ok_q  <= stat_ok_d;
      err_q      <= err_d;
      poll_cnt_q <= poll_cnt_d;
      poll_ph_q  <= poll_ph_d;
      rd_acc_q   <= rd_acc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    sector_d   = sector_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    stat_ok_d  = stat_ok_q;
    err_d      = err_q;
    poll_cnt_d = poll_cnt_q;
    poll_ph_d  = poll_ph_q;
    rd_acc_d   = rd_acc_q;

    cmd.cmd_ready            = 1'b0;
    cmd.resp_valid           = 1'b0;
    cmd.resp_rdata           = '0;
    cmd.resp_error           = 1'b0;
    avmm.avmm_csr_addr       = 1'b0;
    avmm.avmm_csr_read       = 1'b0;
    avmm.avmm_csr_write      = 1'b0;
    avmm.avmm_csr_writedata  = '0;
    avmm.avmm_data_addr      = '0;
    avmm.avmm_data_read      = 1'b0;
    avmm.avmm_data_write     = 1'b0;
    avmm.avmm_data_writedata = '0;

    case (state_q)
      S_IDLE: begin
        cmd.cmd_ready = 1'b1;
        if (cmd.cmd_valid) begin
          op_d       = cmd_op_e'(cmd.cmd_op);
          addr_d     = cmd.cmd_addr;
          sector_d   = cmd.cmd_sector;
          wdata_d    = cmd.cmd_wdata;
          rdata_d    = '0;
          err_d      = 1'b0;
          poll_cnt_d = '0;
          poll_ph_d  = 1'b0;
          rd_acc_d   = 1'b0;
          case (cmd_op_e'(cmd.cmd_op))
            OP_READ:  state_d = S_RD;
            OP_WRITE,
            OP_ERASE: state_d = S_UNPROT;
            default: begin
              err_d   = 1'b1;
              state_d = S_RESP;
            end
          endcase
        end
      end

      S_UNPROT: begin
        avmm.avmm_csr_write     = 1'b1;
        avmm.avmm_csr_addr      = CSR_CTRL_ADDR;
        avmm.avmm_csr_writedata = ctrl_word(5'b00000, SECTOR_NONE);
        state_d = (op_q == OP_WRITE) ? S_WR : S_ERASE;
      end

      S_ERASE: begin
        avmm.avmm_csr_write     = 1'b1;
        avmm.avmm_csr_addr      = CSR_CTRL_ADDR;
        avmm.avmm_csr_writedata = ctrl_word(5'b00000, sector_q);
        state_d = S_POLL;
      end

      S_WR: begin
        avmm.avmm_data_write     = 1'b1;
        avmm.avmm_data_addr      = addr_q;
        avmm.avmm_data_writedata = wdata_q;
        if (!avmm.avmm_data_waitrequest) state_d = S_POLL;
      end

      // Address phase until accepted, then wait for the returned word.
      S_RD: begin
        avmm.avmm_data_read = !rd_acc_q;
        avmm.avmm_data_addr = addr_q;
        if (!rd_acc_q && !avmm.avmm_data_waitrequest) rd_acc_d = 1'b1;
        if (rd_acc_q && avmm.avmm_data_readdatavalid) begin
          rdata_d = avmm.avmm_data_readdata;
          state_d = S_RESP;
        end
      end

      // Phase 0 strobes the status read; phase 1 sees its data.
      S_POLL: begin
        if (!poll_ph_q) begin
          avmm.avmm_csr_read = 1'b1;
          avmm.avmm_csr_addr = CSR_STATUS_ADDR;
          poll_cnt_d = poll_cnt_q + 24'd1;
          poll_ph_d  = 1'b1;
        end else begin
          poll_ph_d = 1'b0;
          if (avmm.avmm_csr_readdata[STAT_BUSY_LSB +: 2] == 2'b00) begin
            stat_ok_d = {avmm.avmm_csr_readdata[STAT_ERASE_OK], avmm.avmm_csr_readdata[STAT_WRITE_OK]};
            state_d   = S_CHECK;
          end else if (poll_cnt_q >= POLL_LIMIT) begin
            err_d   = 1'b1;
            state_d = S_REPROT;
          end
        end
      end

      S_CHECK: begin
        if ((op_q == OP_WRITE) ? !stat_ok_q[0] : !stat_ok_q[1]) err_d = 1'b1;
        state_d = S_REPROT;
      end

      S_REPROT: begin
        avmm.avmm_csr_write     = 1'b1;
        avmm.avmm_csr_addr      = CSR_CTRL_ADDR;
        avmm.avmm_csr_writedata = ctrl_word(WP_MASK, SECTOR_NONE);
        state_d = S_RESP;
      end

      S_RESP: begin
        cmd.resp_valid = 1'b1;
        cmd.resp_rdata = rdata_q;
        cmd.resp_error = err_q;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_onchip_flash_ctrl.sv
// Directed bench for onchip_flash_ctrl: a behavioural flash responder plus scoreboard queues
// for CSR writes, data writes, read addresses and responses.
`timescale 1ns/1ps
module tb_onchip_flash_ctrl;
  import onchip_flash_pkg::*;

  localparam logic [31:0] CTRL_UNPROT  = 32'h007F_FFFF;
  localparam logic [31:0] CTRL_REPROT  = 32'h0FFF_FFFF;
  localparam logic [31:0] CTRL_ERASE3  = 32'h003F_FFFF;
  localparam logic [31:0] CTRL_ERASE0  = 32'h000F_FFFF;

  logic   clock;
  logic   reset;
  state_e state, state2;

  flash_cmd_if  cmd();
  flash_avmm_if avmm();
  flash_cmd_if  cmd2();
  flash_avmm_if avmm2();

  onchip_flash_ctrl dut (
    .clock(clock), .reset(reset), .cmd(cmd), .avmm(avmm), .state_o(state)
  );

  onchip_flash_ctrl #(.POLL_LIMIT(24'd4), .WP_MASK(5'b11111)) dut_lim (
    .clock(clock), .reset(reset), .cmd(cmd2), .avmm(avmm2), .state_o(state2)
  );

  int checks = 0;
  int errors = 0;

  int          wait_cfg = 0;
  int          rdv_delay = 1;
  int          busy_polls = 0;
  int          poll_base = 0;
  logic [31:0] rd_value = '0;
  logic [31:0] final_status = '0;

  int wait_ctr = 0;
  int rdv_pend = 0;
  int csr_reads = 0;
  int dr_cycles = 0;
  int strobe_cycles = 0;
  int resp_count = 0;

  int          csr2_reads = 0;
  int          csr2_writes = 0;
  int          data2_cycles = 0;
  int          resp2_count = 0;
  logic        resp2_error = 1'b0;
  logic [31:0] csr2_last = '0;

  logic [31:0] exp_csr_q[$];
  logic [48:0] exp_dwr_q[$];
  logic [16:0] exp_rda_q[$];
  logic [32:0] exp_resp_q[$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic void check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  // Flash responder and bus monitor for the main instance.
  always @(negedge clock) begin
    if (reset) begin
      avmm.avmm_data_waitrequest   = 1'b1;
      avmm.avmm_data_readdatavalid = 1'b0;
      avmm.avmm_data_readdata      = '0;
      avmm.avmm_csr_readdata       = '0;
      wait_ctr = 0;
      rdv_pend = 0;
    end else begin
      avmm.avmm_data_readdatavalid = 1'b0;
      if (rdv_pend > 0) begin
        rdv_pend--;
        if (rdv_pend == 0) begin
          avmm.avmm_data_readdatavalid = 1'b1;
          avmm.avmm_data_readdata      = rd_value;
        end
      end
      if (avmm.avmm_data_read || avmm.avmm_data_write) begin
        if (wait_ctr < wait_cfg) begin
          avmm.avmm_data_waitrequest = 1'b1;
          wait_ctr++;
        end else begin
          avmm.avmm_data_waitrequest = 1'b0;
          wait_ctr = 0;
          if (avmm.avmm_data_read) begin
            rdv_pend = rdv_delay;
            check("rd_addr_pending", exp_rda_q.size() != 0, 1);
            if (exp_rda_q.size() != 0) check("rd_addr", avmm.avmm_data_addr, exp_rda_q.pop_front());
          end
          if (avmm.avmm_data_write) begin
            check("dwr_pending", exp_dwr_q.size() != 0, 1);
            if (exp_dwr_q.size() != 0)
              check("data_write", {avmm.avmm_data_addr, avmm.avmm_data_writedata}, exp_dwr_q.pop_front());
          end
        end
      end else begin
        avmm.avmm_data_waitrequest = 1'b1;
      end
      if (avmm.avmm_data_read) dr_cycles++;
      if (avmm.avmm_csr_read) begin
        csr_reads++;
        check("csr_rd_addr", avmm.avmm_csr_addr, 0);
        avmm.avmm_csr_readdata = ((csr_reads - poll_base) <= busy_polls) ? 32'h0000_0001 : final_status;
      end
      if (avmm.avmm_csr_write) begin
        check("csr_wr_addr", avmm.avmm_csr_addr, 1);
        check("csr_wr_pending", exp_csr_q.size() != 0, 1);
        if (exp_csr_q.size() != 0) check("csr_wr_data", avmm.avmm_csr_writedata, exp_csr_q.pop_front());
      end
      check("rd_wr_overlap", avmm.avmm_data_read & avmm.avmm_data_write, 0);
      check("csr_data_overlap",
            (avmm.avmm_csr_read | avmm.avmm_csr_write) & (avmm.avmm_data_read | avmm.avmm_data_write), 0);
      if (avmm.avmm_data_read || avmm.avmm_data_write || avmm.avmm_csr_read || avmm.avmm_csr_write)
        strobe_cycles++;
      if (cmd.resp_valid) begin
        resp_count++;
        check("resp_pending", exp_resp_q.size() != 0, 1);
        if (exp_resp_q.size() != 0) check("resp", {cmd.resp_error, cmd.resp_rdata}, exp_resp_q.pop_front());
      end
    end
  end

  // Second instance sees a flash that never leaves busy.
  initial begin
    avmm2.avmm_data_waitrequest   = 1'b0;
    avmm2.avmm_data_readdatavalid = 1'b0;
    avmm2.avmm_data_readdata      = '0;
    avmm2.avmm_csr_readdata       = 32'h0000_0001;
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (avmm2.avmm_csr_read) csr2_reads++;
      if (avmm2.avmm_csr_write) begin
        csr2_writes++;
        csr2_last = avmm2.avmm_csr_writedata;
      end
      if (avmm2.avmm_data_read || avmm2.avmm_data_write) data2_cycles++;
      if (cmd2.resp_valid) begin
        resp2_count++;
        resp2_error = cmd2.resp_error;
      end
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [16:0] addr,
                          input logic [2:0] sec, input logic [31:0] wd);
    int n;
    @(negedge clock);
    cmd.cmd_valid  = 1'b1;
    cmd.cmd_op     = op;
    cmd.cmd_addr   = addr;
    cmd.cmd_sector = sec;
    cmd.cmd_wdata  = wd;
    n = 0;
    while (cmd.cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("cmd_accept", cmd.cmd_ready, 1);
    @(posedge clock);
    #1 cmd.cmd_valid = 1'b0;
  endtask

  task automatic wait_resp(input int base, input int count, input int budget);
    int n;
    n = 0;
    while ((resp_count - base) < count && n < budget) begin
      @(negedge clock);
      #1;
      n++;
    end
    check("resp_count", resp_count - base, count);
  endtask

  initial begin
    int base, r0, s0, n;
    logic [31:0] rnd;

    cmd.cmd_valid   = 1'b0;
    cmd.cmd_op      = 2'b00;
    cmd.cmd_addr    = '0;
    cmd.cmd_sector  = '0;
    cmd.cmd_wdata   = '0;
    cmd2.cmd_valid  = 1'b0;
    cmd2.cmd_op     = 2'b00;
    cmd2.cmd_addr   = '0;
    cmd2.cmd_sector = '0;
    cmd2.cmd_wdata  = '0;

    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_ready", cmd.cmd_ready, 1);
    check("rst_burst", avmm.avmm_data_burstcount, 1);
    check("rst_strobes", {avmm.avmm_data_read, avmm.avmm_data_write, avmm.avmm_csr_read,
                          avmm.avmm_csr_write, cmd.resp_valid, cmd.resp_error}, 0);
    check("rst_rdata", cmd.resp_rdata, 0);
    check("rst_state", state, S_IDLE);
    check("rst_ready_lim", cmd2.cmd_ready, 1);
    reset = 1'b0;

    // Read with two waitrequest cycles and data three cycles after acceptance.
    wait_cfg = 2; rdv_delay = 3; rd_value = 32'hDEAD_BEEF;
    base = resp_count; r0 = dr_cycles;
    exp_rda_q.push_back(17'h00010);
    exp_resp_q.push_back({1'b0, 32'hDEAD_BEEF});
    send_cmd(OP_READ, 17'h00010, 3'd0, 32'h0);
    wait_resp(base, 1, 100);
    check("rd_strobe_cycles", dr_cycles - r0, 3);

    // Write succeeding after two busy polls; a reserved command waits behind it.
    wait_cfg = 1; busy_polls = 2; final_status = 32'h0000_0008; poll_base = csr_reads;
    base = resp_count; r0 = csr_reads;
    exp_csr_q.push_back(CTRL_UNPROT);
    exp_csr_q.push_back(CTRL_REPROT);
    exp_dwr_q.push_back({17'h00004, 32'h1234_5678});
    exp_resp_q.push_back({1'b0, 32'h0});
    exp_resp_q.push_back({1'b1, 32'h0});
    send_cmd(OP_WRITE, 17'h00004, 3'd0, 32'h1234_5678);
    cmd.cmd_valid = 1'b1;
    cmd.cmd_op    = OP_RSVD;
    @(negedge clock);
    #1;
    check("busy_ready_low", cmd.cmd_ready, 0);
    check("busy_no_resp", resp_count - base, 0);
    send_cmd(OP_RSVD, 17'h0, 3'd0, 32'h0);
    wait_resp(base, 2, 100);
    check("wr_status_reads", csr_reads - r0, 3);
    check("wr_csr_all_seen", exp_csr_q.size(), 0);
    check("wr_data_all_seen", exp_dwr_q.size(), 0);

    // Erase sector 3: ten busy polls, then idle with erase-ok clear.
    busy_polls = 10; final_status = 32'h0000_0000; poll_base = csr_reads;
    base = resp_count; r0 = csr_reads;
    exp_csr_q.push_back(CTRL_UNPROT);
    exp_csr_q.push_back(CTRL_ERASE3);
    exp_csr_q.push_back(CTRL_REPROT);
    exp_resp_q.push_back({1'b1, 32'h0});
    send_cmd(OP_ERASE, 17'h0, 3'd3, 32'h0);
    wait_resp(base, 1, 200);
    check("er_status_reads", csr_reads - r0, 11);
    check("er_csr_all_seen", exp_csr_q.size(), 0);

    // Erase sector 0 succeeding on the first poll.
    busy_polls = 0; final_status = 32'h0000_0010; poll_base = csr_reads;
    base = resp_count; r0 = csr_reads;
    exp_csr_q.push_back(CTRL_UNPROT);
    exp_csr_q.push_back(CTRL_ERASE0);
    exp_csr_q.push_back(CTRL_REPROT);
    exp_resp_q.push_back({1'b0, 32'h0});
    send_cmd(OP_ERASE, 17'h0, 3'd0, 32'h0);
    wait_resp(base, 1, 100);
    check("er0_status_reads", csr_reads - r0, 1);

    // Write at the top address where only the erase-ok bit is set: must report failure.
    rnd = $urandom;
    wait_cfg = 0; busy_polls = 1; final_status = 32'h0000_0010; poll_base = csr_reads;
    base = resp_count;
    exp_csr_q.push_back(CTRL_UNPROT);
    exp_csr_q.push_back(CTRL_REPROT);
    exp_dwr_q.push_back({17'h1FFFF, rnd});
    exp_resp_q.push_back({1'b1, 32'h0});
    send_cmd(OP_WRITE, 17'h1FFFF, 3'd0, rnd);
    wait_resp(base, 1, 100);
    check("wrf_csr_all_seen", exp_csr_q.size(), 0);

    // Reserved opcode alone: response the cycle after acceptance, no bus activity.
    s0 = strobe_cycles; base = resp_count;
    exp_resp_q.push_back({1'b1, 32'h0});
    send_cmd(OP_RSVD, 17'h1FFFF, 3'd7, 32'hFFFF_FFFF);
    @(negedge clock);
    #1;
    check("rsvd_resp_next_cycle", resp_count - base, 1);
    @(negedge clock);
    #1;
    check("rsvd_single_pulse", resp_count - base, 1);
    check("rsvd_no_strobes", strobe_cycles - s0, 0);

    // Read at the top address, no wait states, random data.
    rnd = $urandom_range(32'hFFFF_FFFF, 0);
    wait_cfg = 0; rdv_delay = 1; rd_value = rnd;
    base = resp_count;
    exp_rda_q.push_back(17'h1FFFF);
    exp_resp_q.push_back({1'b0, rnd});
    send_cmd(OP_READ, 17'h1FFFF, 3'd0, 32'h0);
    wait_resp(base, 1, 100);

    // Reset while the data write is stalled by waitrequest.
    wait_cfg = 1000; base = resp_count;
    exp_csr_q.push_back(CTRL_UNPROT);
    send_cmd(OP_WRITE, 17'h00020, 3'd0, 32'hA5A5_A5A5);
    n = 0;
    while (avmm.avmm_data_write !== 1'b1 && n < 20) begin
      @(negedge clock);
      #1;
      n++;
    end
    check("wr_strobe_seen", avmm.avmm_data_write, 1);
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("rst_drops_write", avmm.avmm_data_write, 0);
    check("rst_mid_ready", cmd.cmd_ready, 1);
    check("rst_mid_state", state, S_IDLE);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    wait_cfg = 0;
    repeat (20) @(negedge clock);
    #1;
    check("rst_no_resp", resp_count - base, 0);
    check("rst_csr_q_empty", exp_csr_q.size(), 0);

    // Poll limit of 4 against a permanently busy flash.
    @(negedge clock);
    cmd2.cmd_valid  = 1'b1;
    cmd2.cmd_op     = OP_ERASE;
    cmd2.cmd_sector = 3'd5;
    @(posedge clock);
    #1 cmd2.cmd_valid = 1'b0;
    n = 0;
    while (resp2_count == 0 && n < 100) begin
      @(negedge clock);
      #1;
      n++;
    end
    check("lim_resp_seen", resp2_count, 1);
    check("lim_error", resp2_error, 1);
    check("lim_status_reads", csr2_reads, 4);
    check("lim_csr_writes", csr2_writes, 3);
    check("lim_reprot", csr2_last, CTRL_REPROT);
    check("lim_no_data", data2_cycles, 0);

    repeat (5) @(negedge clock);
    #1;
    check("end_resp_q_empty", exp_resp_q.size(), 0);
    check("end_dwr_q_empty", exp_dwr_q.size(), 0);
    check("end_rda_q_empty", exp_rda_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/onchip_flash_ctrl.md
ONCHIP_FLASH_CTRL -- requirements
Module: onchip_flash_ctrl

Interface
REQ-001 SHALL have parameter POLL_LIMIT, default 24'd1048575, max CSR status polls per operation before timeout.
REQ-002 SHALL have parameter WP_MASK, default 5'b11111, write-protect bits restored after each write/erase.
REQ-003 clock  in  1  single clock; all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 cmd_valid  in  1 / cmd_ready  out  1  command handshake; transfer when both high.
REQ-006 cmd_op  in  2  00 read, 01 write, 10 sector erase, 11 reserved (error).
REQ-007 cmd_addr  in  17  word address; cmd_sector  in  3  sector for erase; cmd_wdata  in  32.
REQ-008 resp_valid  out  1  one-cycle pulse; resp_rdata  out  32; resp_error  out  1.
REQ-009 avmm_csr_addr out 1; avmm_csr_read out 1; avmm_csr_write out 1; avmm_csr_writedata out 32; avmm_csr_readdata in 32.
REQ-010 avmm_data_addr out 17; avmm_data_read out 1; avmm_data_write out 1; avmm_data_writedata out 32; avmm_data_burstcount out 2; avmm_data_readdata in 32; avmm_data_waitrequest in 1; avmm_data_readdatavalid in 1.

Function
REQ-011 SHALL act as Avalon-MM initiator to the on-chip flash responder; one command in flight; avmm_data_burstcount constant 2'd1.
REQ-012 CSR map: addr 0 status (bits[1:0] busy, 00 idle; bit3 write ok; bit4 erase ok), addr 1 control (bits[22:20] sector erase, 3'b111 none; bits[27:23] write protect; bits[19:0] page erase 20'hFFFFF none).
REQ-013 States: IDLE, UNPROT, ERASE, WR, RD, POLL, CHECK, REPROT, RESP.
REQ-014 cmd_ready high only in IDLE; command fields registered on accept.
REQ-015 Read: IDLE->RD; avmm_data_read held with address until waitrequest low; then wait readdatavalid; capture readdata -> RESP, resp_error=0.
REQ-016 Write: IDLE->UNPROT (CSR write addr 1, WP=0, sector 111, page all-ones) ->WR (data write held until waitrequest low) ->POLL->CHECK (bit3) ->REPROT->RESP.
REQ-017 Erase: IDLE->UNPROT->ERASE (CSR write addr 1, WP=0, sector=cmd_sector) ->POLL->CHECK (bit4) ->REPROT->RESP.
REQ-018 CSR accesses SHALL be single-cycle strobes (no waitrequest on CSR); CSR readdata valid the cycle after avmm_csr_read.
REQ-019 POLL: issue CSR read addr 0 every second cycle; leave when bits[1:0]==00; increment 24-bit poll counter per read.
REQ-020 Poll counter reaching POLL_LIMIT SHALL go to REPROT with resp_error=1.
REQ-021 CHECK failure (success bit 0) SHALL set resp_error=1; REPROT still executes.
REQ-022 REPROT: CSR write addr 1, WP=WP_MASK, sector 111, page all-ones.
REQ-023 RESP: resp_valid high exactly one cycle, then IDLE; resp_rdata 0 for write/erase.
REQ-024 cmd_op 11 SHALL go directly to RESP with resp_error=1, no bus activity.
REQ-025 Never assert avmm_data_read and avmm_data_write together; never assert any CSR strobe while a data strobe is high.
REQ-026 cmd_valid during busy SHALL be ignored (not lost: held by initiator, cmd_ready low).

Reset
REQ-027 reset SHALL asynchronously force state IDLE, counters 0, and all outputs 0 except cmd_ready=1 and avmm_data_burstcount=1.
REQ-028 reset mid-operation SHALL drop all bus strobes immediately; no response issued for the aborted command.

Structure
REQ-029 Shared package onchip_flash_pkg: cmd_op encodings, CSR addresses, control/status bit positions, state enum.
REQ-030 No sub-module; single FSM plus poll counter.

Verification
REQ-031 Read addr 17'h00010, responder waitrequest 2 cycles, readdatavalid 3 cycles later with 32'hDEADBEEF -> resp_valid, resp_rdata=32'hDEADBEEF, error 0.
REQ-032 Write 32'h12345678 to 17'h00004 -> CSR writes WP=0 then data write then polls then WP=5'b11111; status bit3=1 -> resp_error=0.
REQ-033 Erase sector 3, status busy for 10 polls then idle with bit4=0 -> resp_error=1, REPROT write observed.
REQ-034 POLL_LIMIT=4, status busy permanently -> exactly 4 status reads, resp_error=1.
REQ-035 Assert reset during WR with waitrequest high -> avmm_data_write 0 same cycle, no resp_valid, cmd_ready=1.
REQ-036 cmd_op=11 -> resp_valid one cycle after accept, resp_error=1, zero CSR/data strobes.
